// File: rtl/fb_pkg.sv
// Shared types and defaults for the framebuffer arbiter slice.
package fb_pkg;
   localparam int FB_WIDTH   = 160;
   localparam int FB_HEIGHT  = 120;
   localparam int FB_COLOR_W = 8;

   typedef enum logic {IDLE, CLEAR} fb_state_t;
   typedef logic [FB_COLOR_W-1:0] color_t;

   function automatic int addr_width(input int w, input int h);
      return $clog2(w * h);
   endfunction
endpackage

// File: rtl/fb_addr_calc.sv
// Linear framebuffer address and bounds check for one (x, y) coordinate.
module fb_addr_calc #(
   parameter int WIDTH  = 160,
   parameter int HEIGHT = 120,
   parameter int ADDR_W = 15
) (
   input  logic [9:0]        x,
   input  logic [8:0]        y,
   output logic [ADDR_W-1:0] addr,
   output logic              in_range
);
   assign addr     = ADDR_W'(y) * ADDR_W'(WIDTH) + ADDR_W'(x);
   assign in_range = (int'(x) < WIDTH) && (int'(y) < HEIGHT);
endmodule

// File: rtl/framebuffer_arbiter.sv
// Single-port pixel RAM scheduler: display read > bulk clear > round-robin writers.
module framebuffer_arbiter
   import fb_pkg::*;
#(
   parameter int WIDTH   = FB_WIDTH,
   parameter int HEIGHT  = FB_HEIGHT,
   parameter int COLOR_W = FB_COLOR_W,
   parameter int ADDR_W  = addr_width(WIDTH, HEIGHT)
) (
   input  logic               CLOCK_50,
   input  logic               reset,
   input  logic               disp_req,
   input  logic [9:0]         disp_x,
   input  logic [8:0]         disp_y,
   output logic [COLOR_W-1:0] disp_pixel,
   output logic               disp_valid,
   input  logic [1:0]         wr_req,
   input  logic [9:0]         wr_x0,
   input  logic [8:0]         wr_y0,
   input  logic [COLOR_W-1:0] wr_c0,
   input  logic [9:0]         wr_x1,
   input  logic [8:0]         wr_y1,
   input  logic [COLOR_W-1:0] wr_c1,
   output logic [1:0]         wr_ack,
   input  logic               clear_req,
   input  logic [COLOR_W-1:0] clear_color,
   output logic               clear_busy,
   output logic               clear_done,
   output logic               err_oob,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic               mem_we,
   output logic [COLOR_W-1:0] mem_wdata,
   input  logic [COLOR_W-1:0] mem_rdata
);
   localparam int STAGES = 2;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WIDTH * HEIGHT - 1);

   logic [ADDR_W-1:0] d_addr, w0_addr, w1_addr;
   logic              d_in, w0_in, w1_in;

   fb_addr_calc #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W)) u_disp (
      .x(disp_x), .y(disp_y), .addr(d_addr), .in_range(d_in));
   fb_addr_calc #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W)) u_wr0 (
      .x(wr_x0), .y(wr_y0), .addr(w0_addr), .in_range(w0_in));
   fb_addr_calc #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W)) u_wr1 (
      .x(wr_x1), .y(wr_y1), .addr(w1_addr), .in_range(w1_in));

   fb_state_t          state, state_nxt;
   logic [ADDR_W-1:0]  cnt, cnt_nxt;
   logic [COLOR_W-1:0] clr_color, clr_color_nxt;
   logic               wr_last, wr_last_nxt;
   logic               rd, gsel, op_load, op_we, done_nxt, oob_set;
   logic [1:0]         pend, ack_nxt;
   logic [ADDR_W-1:0]  op_addr;
   logic [COLOR_W-1:0] op_data;
   logic [STAGES:0]    vld_pipe;
   logic [STAGES-1:0]  inr_pipe;

   // Out-of-range display requests do not touch the RAM, so they leave the slot free.
   assign rd         = disp_req & d_in;
   assign pend       = wr_req & ~wr_ack;
   assign clear_busy = (state == CLEAR);
   assign disp_valid = vld_pipe[STAGES];

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      clr_color_nxt = clr_color;
      wr_last_nxt   = wr_last;
      op_load       = 1'b0;
      op_we         = 1'b0;
      op_addr       = mem_addr;
      op_data       = mem_wdata;
      ack_nxt       = 2'b00;
      done_nxt      = 1'b0;
      oob_set       = 1'b0;
      gsel          = 1'b0;
      if (rd) begin
         op_load = 1'b1;
         op_addr = d_addr;
      end
      case (state)
         IDLE: begin
            if (clear_req) begin
               state_nxt     = CLEAR;
               cnt_nxt       = '0;
               clr_color_nxt = clear_color;
            end else if (!rd && pend != 2'b00) begin
               gsel        = (pend == 2'b11) ? ~wr_last : pend[1];
               wr_last_nxt = gsel;
               ack_nxt     = gsel ? 2'b10 : 2'b01;
               if (gsel ? w1_in : w0_in) begin
                  op_load = 1'b1;
                  op_we   = 1'b1;
                  op_addr = gsel ? w1_addr : w0_addr;
                  op_data = gsel ? wr_c1 : wr_c0;
               end else begin
                  oob_set = 1'b1;
               end
            end
         end
         CLEAR: begin
            if (!rd) begin
               op_load = 1'b1;
               op_we   = 1'b1;
               op_addr = cnt;
               op_data = clr_color;
               cnt_nxt = cnt + 1'b1;
               if (cnt == LAST) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         clr_color <= '0;
         wr_last   <= 1'b1;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         clr_color <= clr_color_nxt;
         wr_last   <= wr_last_nxt;
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         mem_addr   <= '0;
         mem_we     <= 1'b0;
         mem_wdata  <= '0;
         wr_ack     <= 2'b00;
         clear_done <= 1'b0;
         err_oob    <= 1'b0;
         vld_pipe   <= '0;
         inr_pipe   <= '0;
         disp_pixel <= '0;
      end else begin
         mem_we     <= op_we;
         wr_ack     <= ack_nxt;
         clear_done <= done_nxt;
         if (op_load) begin
            mem_addr  <= op_addr;
            mem_wdata <= op_data;
         end
         if (oob_set) err_oob <= 1'b1;
         vld_pipe <= {vld_pipe[STAGES-1:0], disp_req};
         inr_pipe <= {inr_pipe[STAGES-2:0], d_in};
         // RAM data for the read issued two edges ago is on mem_rdata now.
         if (vld_pipe[STAGES-1])
            disp_pixel <= inr_pipe[STAGES-1] ? mem_rdata : '0;
      end
   end
endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Scoreboard bench for framebuffer_arbiter with a behavioural synchronous RAM.
module tb_framebuffer_arbiter;
   import fb_pkg::*;

   logic        CLOCK_50, reset;
   logic        disp_req;
   logic [9:0]  disp_x, wr_x0, wr_x1;
   logic [8:0]  disp_y, wr_y0, wr_y1;
   color_t      disp_pixel, wr_c0, wr_c1, clear_color, mem_wdata, mem_rdata;
   logic        disp_valid, clear_req, clear_busy, clear_done, err_oob, mem_we;
   logic [1:0]  wr_req, wr_ack;
   logic [14:0] mem_addr;

   framebuffer_arbiter dut (
      .CLOCK_50(CLOCK_50), .reset(reset),
      .disp_req(disp_req), .disp_x(disp_x), .disp_y(disp_y),
      .disp_pixel(disp_pixel), .disp_valid(disp_valid),
      .wr_req(wr_req), .wr_x0(wr_x0), .wr_y0(wr_y0), .wr_c0(wr_c0),
      .wr_x1(wr_x1), .wr_y1(wr_y1), .wr_c1(wr_c1), .wr_ack(wr_ack),
      .clear_req(clear_req), .clear_color(clear_color),
      .clear_busy(clear_busy), .clear_done(clear_done), .err_oob(err_oob),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata));

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   typedef struct { color_t pix; int due; } dexp_t;
   typedef struct { logic [1:0] ack; logic we; logic [14:0] addr; color_t data; int due; } wexp_t;

   dexp_t  dq[$];
   wexp_t  wq[$];
   int     checks = 0, errors = 0, cyc = 0;
   color_t ram [0:32767];
   int     wcount [0:19199];
   int     busy_cycles = 0, done_cnt = 0, clr_bad = 0;
   logic   clr_mode = 1'b0;
   color_t clr_exp = 8'h00;

   function automatic color_t pat(input int a);
      return 8'(a) ^ 8'h3C;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   task automatic step();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic push_rd(input int a);
      dexp_t e;
      e.pix = pat(a);
      e.due = cyc + 3;
      dq.push_back(e);
   endtask

   task automatic push_wr(input logic [1:0] ack, input logic we, input int a, input color_t d, input int due);
      wexp_t e;
      e.ack = ack; e.we = we; e.addr = 15'(a); e.data = d; e.due = due;
      wq.push_back(e);
   endtask

   always @(posedge CLOCK_50) begin
      cyc <= cyc + 1;
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   // Monitor: pops scoreboard entries whenever the DUT presents a display pixel or a write grant.
   always @(negedge CLOCK_50) begin
      if (!reset) begin
         if (disp_valid) begin
            if (dq.size() == 0) check("disp_unexpected", 1, 0);
            else begin
               dexp_t e;
               e = dq.pop_front();
               check("disp_pixel", disp_pixel, e.pix);
               check("disp_latency", cyc, e.due);
            end
         end
         if (wr_ack != 2'b00) begin
            if (wq.size() == 0) check("ack_unexpected", wr_ack, 0);
            else begin
               wexp_t e;
               e = wq.pop_front();
               check("ack_id", wr_ack, e.ack);
               check("ack_cycle", cyc, e.due);
               check("ack_we", mem_we, e.we);
               if (e.we) check("ack_addr_data", {mem_addr, mem_wdata}, {e.addr, e.data});
            end
         end
         if (clr_mode && mem_we && wr_ack == 2'b00) begin
            if (mem_addr < 15'd19200) wcount[mem_addr] = wcount[mem_addr] + 1;
            else clr_bad++;
            if (mem_wdata !== clr_exp) clr_bad++;
         end
         if (clear_busy) busy_cycles++;
         if (clear_done) done_cnt++;
      end
   end

   initial begin
      int bad, c;
      logic seen;
      for (int i = 0; i < 32768; i++) ram[i] = pat(i);
      for (int i = 0; i < 19200; i++) wcount[i] = 0;
      mem_rdata = '0;
      reset = 1'b1; disp_req = 0; disp_x = 0; disp_y = 0;
      wr_req = 0; wr_x0 = 0; wr_y0 = 0; wr_c0 = 0; wr_x1 = 0; wr_y1 = 0; wr_c1 = 0;
      clear_req = 0; clear_color = 0;
      #1;
      check("reset_outputs", {disp_valid, disp_pixel, wr_ack, clear_busy, clear_done, err_oob,
                              mem_we, mem_addr, mem_wdata}, 0);
      repeat (3) step();
      reset = 1'b0;
      step();

      // Single display read at (3,2) -> 323.
      disp_req = 1; disp_x = 3; disp_y = 2; push_rd(323);
      step();
      disp_req = 0;
      check("rd_addr", {mem_we, mem_addr}, {1'b0, 15'd323});
      repeat (4) step();

      // Out-of-range read: no RAM access, pixel 0 at the same latency.
      disp_req = 1; disp_x = 200; disp_y = 2;
      begin dexp_t e; e.pix = 8'h00; e.due = cyc + 3; dq.push_back(e); end
      step();
      disp_req = 0;
      check("oob_rd_no_access", {mem_we, mem_addr}, {1'b0, 15'd323});
      repeat (4) step();

      // Back-to-back reads.
      disp_req = 1;
      disp_x = 0;   disp_y = 10;  push_rd(1600);  step();
      disp_x = 1;   disp_y = 10;  push_rd(1601);  step();
      disp_x = 159; disp_y = 0;   push_rd(159);   step();
      disp_x = 0;   disp_y = 119; push_rd(19040); step();
      disp_req = 0;
      repeat (5) step();

      // Both writers continuously: grants alternate starting with writer 0.
      wr_x0 = 10; wr_y0 = 5; wr_c0 = 8'h11;
      wr_x1 = 20; wr_y1 = 6; wr_c1 = 8'h22;
      wr_req = 2'b11;
      c = cyc;
      for (int i = 0; i < 4; i++)
         push_wr((i % 2 == 0) ? 2'b01 : 2'b10, 1'b1, (i % 2 == 0) ? 810 : 980,
                 (i % 2 == 0) ? 8'h11 : 8'h22, c + 1 + i);
      repeat (4) step();
      wr_req = 2'b00;
      repeat (3) step();

      // Display burst of 10 stalls writer 0 until the first free cycle.
      wr_x0 = 7; wr_y0 = 3; wr_c0 = 8'h77;
      wr_req = 2'b01; disp_req = 1; disp_y = 0;
      for (int i = 0; i < 10; i++) begin
         disp_x = 10'(i); push_rd(i); step();
      end
      disp_req = 0;
      push_wr(2'b01, 1'b1, 487, 8'h77, cyc + 1);
      step();
      wr_req = 2'b00;
      repeat (5) step();

      // Out-of-range writer 1: ack without write, sticky error.
      check("err_oob_before", err_oob, 0);
      wr_x1 = 200; wr_y1 = 6; wr_c1 = 8'h99; wr_req = 2'b10;
      push_wr(2'b10, 1'b0, 0, 8'h00, cyc + 1);
      step();
      wr_req = 2'b00;
      repeat (2) step();
      check("err_oob_set", err_oob, 1);

      // Full clear with simultaneous writer request and one stolen display cycle.
      clr_mode = 1; clr_exp = 8'hA5; busy_cycles = 0; done_cnt = 0; clr_bad = 0;
      wr_x0 = 1; wr_y0 = 1; wr_c0 = 8'h3D; wr_req = 2'b01;
      clear_req = 1; clear_color = 8'hA5;
      c = cyc;
      push_wr(2'b01, 1'b1, 161, 8'h3D, c + 19203);
      step();
      clear_req = 0; clear_color = 8'h00;
      seen = 1'b0;
      for (int i = 0; i < 19300 && !seen; i++) begin
         if (i == 100) begin
            disp_req = 1; disp_x = 159; disp_y = 119; push_rd(19199);
         end else disp_req = 0;
         step();
         if (wr_ack[0]) begin wr_req = 2'b00; seen = 1'b1; end
      end
      disp_req = 0; wr_req = 2'b00;
      repeat (3) step();
      clr_mode = 0;
      check("clear_busy_cycles", busy_cycles, 19201);
      check("clear_done_count", done_cnt, 1);
      bad = 0;
      for (int i = 0; i < 19200; i++) if (wcount[i] != 1) bad++;
      check("clear_each_addr_once", bad, 0);
      check("clear_data_bad", clr_bad, 0);
      check("err_oob_sticky", err_oob, 1);

      // Reset mid-clear aborts; a new clear restarts at address 0.
      clr_mode = 1; clr_exp = 8'h5A; done_cnt = 0;
      clear_req = 1; clear_color = 8'h5A;
      step();
      clear_req = 0;
      repeat (50) step();
      check("busy_mid_clear", clear_busy, 1);
      #3 reset = 1'b1;
      #1;
      check("busy_after_async_reset", {clear_busy, clear_done, mem_we, err_oob}, 0);
      repeat (3) step();
      reset = 1'b0;
      repeat (20) step();
      check("no_done_after_abort", done_cnt, 0);
      clr_exp = 8'h3C;
      clear_req = 1; clear_color = 8'h3C;
      step();
      clear_req = 0;
      step();
      check("restart_first_write", {mem_we, mem_addr, mem_wdata}, {1'b1, 15'd0, 8'h3C});
      repeat (10) step();
      clr_mode = 0;
      check("disp_queue_drained", dq.size(), 0);
      check("wr_queue_drained", wq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/framebuffer_arbiter.md
# framebuffer_arbiter

Schedules all access to the single-port pixel RAM that backs the VGA display. Sits between the video driver, which supplies pixel coordinates and consumes colour, and the game-logic drawing engines. One display read port gets fixed top priority. A bulk-clear sequencer comes next, and two drawing write ports share the remaining cycles round-robin.

## Interface
- WIDTH, 160: framebuffer width in pixels.
- HEIGHT, 120: framebuffer height in pixels.
- COLOR_W, 8: bits per stored pixel.
- ADDR_W, $clog2(WIDTH*HEIGHT): RAM address width.
- CLOCK_50  in  1  sole clock; all logic is posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- disp_req  in  1  one-cycle pixel fetch request from the video side.
- disp_x, disp_y  in  10, 9  pixel coordinate for disp_req.
- disp_pixel  out  COLOR_W  fetched colour; 0 when the coordinate is out of range.
- disp_valid  out  1  one-cycle strobe qualifying disp_pixel.
- wr_req  in  2  per-writer write request; held until acked.
- wr_x0/wr_y0/wr_c0, wr_x1/wr_y1/wr_c1  in  10/9/COLOR_W  per-writer coordinate and colour; held stable while wr_req is high.
- wr_ack  out  2  one-cycle grant pulse per writer.
- clear_req  in  1  pulse; starts a full-frame fill.
- clear_color  in  COLOR_W  fill colour, sampled when clear_req is accepted.
- clear_busy  out  1  high while the fill runs.
- clear_done  out  1  one-cycle pulse after the last address is written.
- err_oob  out  1  sticky; set when a writer is acked with an out-of-range coordinate.
- mem_addr  out  ADDR_W  registered RAM address.
- mem_we  out  1  registered RAM write enable.
- mem_wdata  out  COLOR_W  registered RAM write data.
- mem_rdata  in  COLOR_W  RAM read data, valid one cycle after the address.

## Operation
- Address = y*WIDTH + x, computed at ADDR_W bits. A coordinate is in range iff x<WIDTH and y<HEIGHT.
- Each cycle at most one RAM operation is issued. Priority: display read, then clear write, then writers.
- **Display read.**
  - disp_req with an in-range coordinate issues a read (mem_we=0).
  - Out of range: no RAM access; disp_valid still fires at the same latency with disp_pixel=0.
- **FSM states: IDLE and CLEAR.**
  - IDLE→CLEAR on clear_req. The clear counter is set to 0 and clear_color is latched.
  - In CLEAR, every cycle without a display read writes the latched colour at the counter address, then increments the counter.
  - Writing address WIDTH*HEIGHT-1 → IDLE and clear_done pulses.
  - clear_req while in CLEAR is ignored.
- **Writers.**
  - Served only in IDLE, and only in cycles with no display read.
  - Round-robin pointer: the writer not granted most recently wins when both request. The pointer's reset value favours writer 0.
  - Grant → wr_ack pulse. An in-range grant also writes the RAM; an out-of-range grant writes nothing and sets err_oob.
  - A writer is never acked twice for one request: ack deasserts the grant for the cycle after.

## Timing
- disp_req sampled at edge k:
  - mem_addr is registered at edge k.
  - mem_rdata is captured into disp_pixel at edge k+2.
  - disp_valid is high for exactly the cycle after edge k+2. Fixed latency is 2, including out-of-range requests.
- Back-to-back disp_req every cycle is sustained; writers and clear fully stall meanwhile.
- wr_ack is registered in the same edge as its mem_we=1 write.
- Worst-case clear duration is WIDTH*HEIGHT cycles plus stolen display cycles.
- Reset values: disp_valid, disp_pixel, wr_ack, clear_busy, clear_done, err_oob, mem_we, mem_addr, mem_wdata = 0; FSM=IDLE.
- Reset mid-clear aborts the fill, leaving RAM partially filled, and no clear_done is produced.
- Simultaneous clear_req and wr_req in IDLE: clear is accepted; the writer waits until clear_done.

## Structure
- Package fb_pkg holds:
  - the state enum (IDLE, CLEAR);
  - the color_t typedef;
  - WIDTH/HEIGHT defaults;
  - an addr_width() function.
- Sub-module fb_addr_calc: combinational (x, y) → (addr, in_range), instantiated three times (display, writer 0, writer 1).

## Test plan
- Reset, then disp_req at (3,2) with WIDTH=160 → mem_addr=323 at edge k; disp_pixel=mem_rdata and disp_valid at edge k+2.
- Writers 0 and 1 both request continuously with no display traffic → acks alternate 0,1,0,1, each with the correct address and data on mem_wdata.
- disp_req every cycle for 10 cycles while wr_req[0]=1 → no wr_ack during the burst; ack in the first free cycle.
- clear_req with clear_color=8'hA5, one display read injected mid-fill → clear_busy high for 19201 cycles; every address 0..19199 written with A5 exactly once; clear_done once.
- wr_x1=200 → wr_ack[1] pulses, mem_we stays 0, err_oob=1 and stays set.
- Reset asserted asynchronously mid-clear → clear_busy=0 immediately, no clear_done; a later clear_req restarts at address 0.
